// File: rtl/hwpe_stream_package.sv
// Shared control/flag types and FSM state encoding for the HWPE stream TCDM writer.
package hwpe_stream_package;

  localparam int unsigned TCDM_BYTES = 4;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [15:0] trans_size;
    logic [31:0] stride;
  } ctrl_tcdm_writer_t;

  typedef struct packed {
    logic        ready_start;
    logic        done;
    logic        in_progress;
    logic [15:0] beat_cnt;
  } flags_tcdm_writer_t;

  typedef enum logic {
    IDLE,
    WORKING
  } tcdm_writer_state_t;

endpackage

// File: rtl/hwpe_stream_interfaces.sv
// TCDM port and valid/ready data stream interfaces used by the HWPE stream blocks.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_writer_addrgen.sv
// Beat address and beat counter for the TCDM writer; latches the transfer shape on load.
module hwpe_stream_tcdm_writer_addrgen
  import hwpe_stream_package::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load,
  input  logic [31:0] base_addr,
  input  logic [15:0] trans_size,
  input  logic [31:0] stride,
  input  logic        advance,
  output logic [31:0] cur_addr,
  output logic [15:0] beat_cnt,
  output logic        last_beat
);

  logic [31:0] cur_addr_q;
  logic [15:0] beat_cnt_q;
  logic [15:0] trans_size_q;
  logic [31:0] stride_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_addr_q   <= '0;
      beat_cnt_q   <= '0;
      trans_size_q <= '0;
      stride_q     <= '0;
    end else if (clear_i) begin
      cur_addr_q   <= '0;
      beat_cnt_q   <= '0;
      trans_size_q <= '0;
      stride_q     <= '0;
    end else if (load) begin
      cur_addr_q   <= base_addr;
      beat_cnt_q   <= '0;
      trans_size_q <= trans_size;
      stride_q     <= stride;
    end else if (advance) begin
      cur_addr_q <= cur_addr_q + stride_q;
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign cur_addr  = cur_addr_q;
  assign beat_cnt  = beat_cnt_q;
  assign last_beat = ((beat_cnt_q + 16'd1) == trans_size_q);

endmodule

// File: rtl/hwpe_stream_tcdm_writer.sv
// Writes a DATA_WIDTH stream to memory over NB_TCDM_PORTS 32-bit TCDM ports, one strided beat at a time.
module hwpe_stream_tcdm_writer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH/32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  hwpe_stream_intf_tcdm.master   tcdm [NB_TCDM_PORTS-1:0],
  hwpe_stream_intf_stream.sink   stream,
  input  ctrl_tcdm_writer_t      ctrl_i,
  output flags_tcdm_writer_t     flags_o
);

  tcdm_writer_state_t       state_q;
  logic [NB_TCDM_PORTS-1:0] mask_q;
  logic [NB_TCDM_PORTS-1:0] gnt;
  logic [NB_TCDM_PORTS-1:0] req;
  logic                     ready_start_q;
  logic                     in_progress_q;
  logic                     done_q;
  logic                     working;
  logic                     beat_done;
  logic                     load;
  logic                     last_beat;
  logic [31:0]              cur_addr;
  logic [15:0]              beat_cnt;
  logic                     unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // A clear cycle must not issue requests, so it gates the working qualifier.
  assign working = (state_q == WORKING) && !clear_i;

  always_comb begin
    req = '0;
    if (working && stream.valid)
      req = ~mask_q;
  end

  // A beat completes once every port has been granted, in this or an earlier cycle.
  assign beat_done    = working && stream.valid && (&(mask_q | (gnt & req)));
  assign stream.ready = beat_done;

  assign load = (state_q == IDLE) && !clear_i && ctrl_i.req_start
                && (ctrl_i.trans_size != '0);

  for (genvar ii = 0; ii < NB_TCDM_PORTS; ii++) begin : g_port
    logic unused_rsp;
    assign tcdm[ii].req  = req[ii];
    assign tcdm[ii].add  = cur_addr + 32'(TCDM_BYTES * ii);
    assign tcdm[ii].wen  = 1'b0;
    assign tcdm[ii].data = stream.data[32*ii +: 32];
    assign tcdm[ii].be   = stream.strb[4*ii +: 4];
    assign gnt[ii]       = tcdm[ii].gnt;
    assign unused_rsp    = ^{tcdm[ii].r_valid, tcdm[ii].r_data};
  end

  hwpe_stream_tcdm_writer_addrgen i_addrgen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .load       (load),
    .base_addr  (ctrl_i.base_addr),
    .trans_size (ctrl_i.trans_size),
    .stride     (ctrl_i.stride),
    .advance    (beat_done),
    .cur_addr   (cur_addr),
    .beat_cnt   (beat_cnt),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      ready_start_q <= 1'b1;
      in_progress_q <= 1'b0;
      done_q        <= 1'b0;
    end else if (clear_i) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      ready_start_q <= 1'b1;
      in_progress_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mask_q <= '0;
          done_q <= ctrl_i.req_start && (ctrl_i.trans_size == '0);
          if (load) begin
            state_q       <= WORKING;
            ready_start_q <= 1'b0;
            in_progress_q <= 1'b1;
          end
        end
        WORKING: begin
          done_q <= 1'b0;
          if (beat_done) begin
            mask_q <= '0;
            if (last_beat) begin
              state_q       <= IDLE;
              ready_start_q <= 1'b1;
              in_progress_q <= 1'b0;
              done_q        <= 1'b1;
            end
          end else begin
            mask_q <= mask_q | (gnt & req);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flags_o.ready_start = ready_start_q;
  assign flags_o.done        = done_q;
  assign flags_o.in_progress = in_progress_q;
  assign flags_o.beat_cnt    = beat_cnt;

endmodule

// File: tb/tb_hwpe_stream_tcdm_writer.sv
// Bench for hwpe_stream_tcdm_writer: directed vector table, corner sequences, and a randomized model run.
module tb_hwpe_stream_tcdm_writer;
  import hwpe_stream_package::*;

  localparam int unsigned DW = 64;
  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_d = 1'b0, valid_d = 1'b0, clr_d = 1'b0;
  logic [15:0]   size_d = '0;
  logic [31:0]   base_d = '0, stride_d = '0;
  logic [NP-1:0] t_gnt = '0;
  logic [7:0]    strb_d = '0;
  logic [63:0]   data_d = '0;

  logic [NP-1:0] t_req, t_wen;
  logic [31:0]   t_add [NP];
  logic [31:0]   t_data [NP];
  logic [3:0]    t_be [NP];
  logic          s_ready;

  ctrl_tcdm_writer_t  ctrl;
  flags_tcdm_writer_t flags;

  hwpe_stream_intf_tcdm tcdm_if [NP-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) stream_if ();

  for (genvar g = 0; g < NP; g++) begin : g_port
    assign t_req[g]          = tcdm_if[g].req;
    assign t_wen[g]          = tcdm_if[g].wen;
    assign t_add[g]          = tcdm_if[g].add;
    assign t_data[g]         = tcdm_if[g].data;
    assign t_be[g]           = tcdm_if[g].be;
    assign tcdm_if[g].gnt    = t_gnt[g];
    assign tcdm_if[g].r_valid = 1'b0;
    assign tcdm_if[g].r_data  = '0;
  end

  assign stream_if.valid = valid_d;
  assign stream_if.data  = data_d;
  assign stream_if.strb  = strb_d;
  assign s_ready         = stream_if.ready;
  assign ctrl.req_start  = start_d;
  assign ctrl.base_addr  = base_d;
  assign ctrl.trans_size = size_d;
  assign ctrl.stride     = stride_d;

  hwpe_stream_tcdm_writer #(.DATA_WIDTH(DW), .NB_TCDM_PORTS(NP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (1'b0),
    .clear_i     (clr_d),
    .tcdm        (tcdm_if),
    .stream      (stream_if),
    .ctrl_i      (ctrl),
    .flags_o     (flags)
  );

  typedef struct {
    logic [1:0]  req;
    logic        ready;
    logic [31:0] add0;
    logic        done;
    logic        rs;
    logic        ip;
    logic [15:0] beat;
  } exp_t;

  typedef struct {
    logic        start;
    logic [15:0] size;
    logic [31:0] base;
    logic [31:0] stride;
    logic        valid;
    logic [1:0]  gnt;
    logic [7:0]  strb;
    logic        clr;
    exp_t        e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t v(logic st, logic [15:0] sz, logic [31:0] ba, logic [31:0] sr,
                             logic vl, logic [1:0] gn, logic [7:0] sb, logic cl,
                             logic [1:0] ereq, logic erdy, logic [31:0] eadd,
                             logic edone, logic ers, logic eip, logic [15:0] ebeat);
    vec_t r;
    r.start = st; r.size = sz; r.base = ba; r.stride = sr;
    r.valid = vl; r.gnt = gn; r.strb = sb; r.clr = cl;
    r.e.req = ereq; r.e.ready = erdy; r.e.add0 = eadd;
    r.e.done = edone; r.e.rs = ers; r.e.ip = eip; r.e.beat = ebeat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    for (int p = 0; p < int'(NP); p++) begin
      chk($sformatf("%s req%0d", tag, p), 32'(t_req[p]), 32'(e.req[p]));
      if (e.req[p]) begin
        chk($sformatf("%s add%0d", tag, p), t_add[p], e.add0 + 32'(4 * p));
        chk($sformatf("%s wen%0d", tag, p), 32'(t_wen[p]), 32'd0);
        chk($sformatf("%s data%0d", tag, p), t_data[p], data_d[32*p +: 32]);
        chk($sformatf("%s be%0d", tag, p), 32'(t_be[p]), 32'(strb_d[4*p +: 4]));
      end
    end
    chk({tag, " ready"}, 32'(s_ready), 32'(e.ready));
    chk({tag, " done"}, 32'(flags.done), 32'(e.done));
    chk({tag, " ready_start"}, 32'(flags.ready_start), 32'(e.rs));
    chk({tag, " in_progress"}, 32'(flags.in_progress), 32'(e.ip));
    chk({tag, " beat_cnt"}, 32'(flags.beat_cnt), 32'(e.beat));
  endtask

  task automatic drive(input vec_t x);
    start_d = x.start; size_d = x.size; base_d = x.base; stride_d = x.stride;
    valid_d = x.valid; t_gnt = x.gnt; strb_d = x.strb; clr_d = x.clr;
    data_d = {$urandom, $urandom};
  endtask

  task automatic apply_vec(input string tag, input vec_t x);
    drive(x);
    #1;
    check_outputs(tag, x.e);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // Behavioural model state for the random run.
  bit          m_busy, m_done;
  int unsigned m_k, m_size;
  logic [31:0] m_base, m_stride;
  bit [NP-1:0] m_gr;

  initial begin
    exp_t e;
    vec_t x;

    // always-grant streaming, wrap-free base
    tbl.push_back(v(1, 3, 32'h100, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         0, 1, 0, 0));
    tbl.push_back(v(0, 3, 32'h100, 8, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'h100,   0, 0, 1, 0));
    tbl.push_back(v(0, 3, 32'h100, 8, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'h108,   0, 0, 1, 1));
    tbl.push_back(v(0, 3, 32'h100, 8, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'h110,   0, 0, 1, 2));
    tbl.push_back(v(0, 3, 32'h100, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         1, 1, 0, 3));
    tbl.push_back(v(0, 3, 32'h100, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         0, 1, 0, 3));
    // partial strobe
    tbl.push_back(v(1, 1, 32'h200, 4, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         0, 1, 0, 3));
    tbl.push_back(v(0, 1, 32'h200, 4, 1, 2'b11, 8'h0F, 0, 2'b11, 1, 32'h200,   0, 0, 1, 0));
    tbl.push_back(v(0, 1, 32'h200, 4, 0, 2'b11, 8'h0F, 0, 2'b00, 0, 0,         1, 1, 0, 1));
    // zero-size start
    tbl.push_back(v(1, 0, 32'h500, 4, 1, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         0, 1, 0, 1));
    tbl.push_back(v(0, 0, 32'h500, 4, 1, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         1, 1, 0, 1));
    tbl.push_back(v(0, 0, 32'h500, 4, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,         0, 1, 0, 1));
    // address wrap
    tbl.push_back(v(1, 2, 32'hFFFFFFF8, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,          0, 1, 0, 1));
    tbl.push_back(v(0, 2, 32'hFFFFFFF8, 8, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'hFFFFFFF8, 0, 0, 1, 0));
    tbl.push_back(v(0, 2, 32'hFFFFFFF8, 8, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'h0,        0, 0, 1, 1));
    tbl.push_back(v(0, 2, 32'hFFFFFFF8, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,            1, 1, 0, 2));
    tbl.push_back(v(0, 2, 32'hFFFFFFF8, 8, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,            0, 1, 0, 2));

    // reset state, with a start and valid stream pending
    drive(v(1, 3, 32'h100, 8, 1, 2'b11, 8'hFF, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    #7;
    x = v(1, 3, 32'h100, 8, 1, 2'b11, 8'hFF, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    check_outputs("reset", x.e);
    start_d = 1'b0; valid_d = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply_vec($sformatf("tbl%0d", i), tbl[i]);

    // staggered grant, then a valid drop mid-beat with one port already granted
    apply_vec("stg0", v(1, 2, 32'h300, 32'h10, 0, 2'b00, 8'hFF, 0, 2'b00, 0, 0,       0, 1, 0, 2));
    apply_vec("stg1", v(0, 2, 32'h300, 32'h10, 1, 2'b01, 8'hFF, 0, 2'b11, 0, 32'h300, 0, 0, 1, 0));
    apply_vec("stg2", v(0, 2, 32'h300, 32'h10, 1, 2'b00, 8'hFF, 0, 2'b10, 0, 32'h300, 0, 0, 1, 0));
    apply_vec("stg3", v(0, 2, 32'h300, 32'h10, 1, 2'b10, 8'hFF, 0, 2'b10, 1, 32'h300, 0, 0, 1, 0));
    apply_vec("stg4", v(0, 2, 32'h300, 32'h10, 1, 2'b10, 8'hFF, 0, 2'b11, 0, 32'h310, 0, 0, 1, 1));
    apply_vec("stg5", v(0, 2, 32'h300, 32'h10, 0, 2'b00, 8'hFF, 0, 2'b00, 0, 0,       0, 0, 1, 1));
    apply_vec("stg6", v(0, 2, 32'h300, 32'h10, 1, 2'b01, 8'hFF, 0, 2'b01, 1, 32'h310, 0, 0, 1, 1));
    apply_vec("stg7", v(0, 2, 32'h300, 32'h10, 0, 2'b00, 8'hFF, 0, 2'b00, 0, 0,       1, 1, 0, 2));

    // clear after the first beat of four
    apply_vec("clr0", v(1, 4, 32'h400, 4, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,       0, 1, 0, 2));
    apply_vec("clr1", v(0, 4, 32'h400, 4, 1, 2'b11, 8'hFF, 0, 2'b11, 1, 32'h400, 0, 0, 1, 0));
    apply_vec("clr2", v(0, 4, 32'h400, 4, 1, 2'b11, 8'hFF, 1, 2'b00, 0, 0,       0, 0, 1, 1));
    apply_vec("clr3", v(0, 4, 32'h400, 4, 1, 2'b11, 8'hFF, 0, 2'b00, 0, 0,       0, 1, 0, 0));
    apply_vec("clr4", v(0, 4, 32'h400, 4, 0, 2'b11, 8'hFF, 0, 2'b00, 0, 0,       0, 1, 0, 0));

    // random run against the transfer-level model, starting from a cleared block
    drive(v(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 2'b00, 0, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    m_busy = 0; m_done = 0; m_k = 0; m_size = 0; m_base = '0; m_stride = '0; m_gr = '0;

    for (int c = 0; c < 600; c++) begin
      bit all_g;
      x = v($urandom_range(3) == 0, 16'($urandom_range(4)), $urandom, $urandom,
            $urandom_range(4) != 0, 2'($urandom), 8'($urandom), $urandom_range(49) == 0,
            2'b00, 0, 0, 0, 0, 0, 0);
      drive(x);
      all_g = 1;
      for (int p = 0; p < int'(NP); p++) begin
        e.req[p] = m_busy && x.valid && !x.clr && !m_gr[p];
        if (!(m_gr[p] || (e.req[p] && x.gnt[p]))) all_g = 0;
      end
      e.ready = m_busy && x.valid && !x.clr && all_g;
      e.add0  = m_base + 32'(m_k) * m_stride;
      e.done  = m_done;
      e.rs    = !m_busy;
      e.ip    = m_busy;
      e.beat  = 16'(m_k);
      #1;
      check_outputs($sformatf("rnd%0d", c), e);
      @(posedge clk);
      #1;
      if (x.clr) begin
        m_busy = 0; m_k = 0; m_gr = '0; m_done = 0;
      end else if (!m_busy) begin
        m_done = x.start && (x.size == 0);
        if (x.start && x.size != 0) begin
          m_busy = 1; m_k = 0; m_gr = '0;
          m_size = x.size; m_base = x.base; m_stride = x.stride;
        end
      end else begin
        m_done = 0;
        if (e.ready) begin
          m_k++;
          m_gr = '0;
          if (m_k == m_size) begin
            m_busy = 0;
            m_done = 1;
          end
        end else begin
          m_gr = m_gr | (e.req & x.gnt);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_writer.md
HWPE_STREAM_TCDM_WRITER -- requirements
Module: hwpe_stream_tcdm_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: input stream width in bits, a multiple of 32.
REQ-002 SHALL have parameter NB_TCDM_PORTS, default DATA_WIDTH/32: number of 32-bit TCDM write ports.
REQ-003 SHALL have clk_i, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have test_mode_i, input, 1: test mode, functionally unused.
REQ-006 SHALL have clear_i, input, 1: synchronous clear, active-high.
REQ-007 SHALL have tcdm, hwpe_stream_intf_tcdm.master array [NB_TCDM_PORTS-1:0]: TCDM write ports.
REQ-008 SHALL have stream, hwpe_stream_intf_stream.sink, DATA_WIDTH: the input data stream.
REQ-009 SHALL have ctrl_i, input, ctrl_tcdm_writer_t, with fields req_start, base_addr[31:0], trans_size[15:0] (beats) and stride[31:0] (bytes per beat).
REQ-010 SHALL have flags_o, output, flags_tcdm_writer_t, with fields ready_start, done, in_progress and beat_cnt[15:0].

Function
REQ-011 SHALL implement a state machine with states IDLE and WORKING.
REQ-012 IDLE: ready_start=1 and no TCDM req; on req_start with trans_size!=0, latch base_addr, trans_size and stride, clear beat_cnt and go to WORKING.
REQ-013 IDLE with req_start and trans_size==0: stay IDLE, pulse done one cycle later, issue no TCDM request.
REQ-014 WORKING: in_progress=1; ctrl_i changes are ignored until the block returns to IDLE.
REQ-015 Port ii SHALL drive add=cur_addr+4*ii, wen=0 (write), data=stream.data[32*ii+:32], be=stream.strb[4*ii+:4].
REQ-016 Port ii SHALL assert req only when WORKING, stream.valid=1 and bit ii of the per-beat grant mask is 0.
REQ-017 The grant mask SHALL set bit ii on tcdm[ii].gnt during req; ports granted in earlier cycles drop req while the others keep requesting.
REQ-018 Beat completion SHALL be (mask | gnt-this-cycle) all ones.
REQ-019 stream.ready SHALL be 1 only in the completion cycle, never depending on stream.valid being low; the handshake is combinational on gnt.
REQ-020 On completion: mask clears, cur_addr+=stride (modulo 2^32) and beat_cnt increments, all in the same cycle.
REQ-021 Completion of beat trans_size SHALL return the machine to IDLE; done SHALL be a registered 1-cycle pulse in the following cycle.
REQ-022 The block SHALL rely on stream data stability while valid=1 and not ready, and SHALL NOT buffer data.
REQ-023 r_valid/r_data from TCDM SHALL be ignored.
REQ-024 stream.valid deasserting mid-beat (protocol violation) SHALL drop all req; the mask SHALL be held.

Reset
REQ-025 Under rst_ni=0: state=IDLE, mask=0, cur_addr=0, beat_cnt=0, done=0, all req=0, stream.ready=0.
REQ-026 clear_i=1 SHALL have the same effect as reset on the next edge, including mid-transfer; no TCDM req is issued in the clear cycle.

Structure
REQ-027 ctrl_tcdm_writer_t, flags_tcdm_writer_t and the state enum SHALL live in hwpe_stream_package.
REQ-028 The address/beat counter SHALL be one sub-module, hwpe_stream_tcdm_writer_addrgen; the FSM, mask and port binding stay at top level.

Verification
REQ-029 Always-grant, NB_TCDM_PORTS=2, base=0x100, size=3, stride=8: writes at 0x100/0x104, 0x108/0x10C, 0x110/0x114 on 3 consecutive cycles; done pulses 1 cycle after the last.
REQ-030 Staggered grant, port0 at cycle 0 and port1 at cycle 2: port0 req drops after cycle 0; stream.ready is high only at cycle 2; one beat is counted.
REQ-031 Partial strb=0x0F on DATA_WIDTH=64: port0 be=0xF and port1 be=0x0; both ports still request.
REQ-032 size=0 start: no req is seen, done pulses once, ready_start stays 1.
REQ-033 clear_i asserted after beat 1 of 4: next cycle state is IDLE, beat_cnt=0, no done, no req.
REQ-034 base=0xFFFFFFF8, stride=8, size=2: second beat is written at 0x00000000/0x00000004.
